register_transfer_sequencer: RTL

- Initiator side of the latched-register bus interface: sequences one word transfer from a source register to a destination register over the shared 32-bit tri-state bus.
- For each transfer it drives the active-low output-enable of one source register and the latch-enable of one destination register.
- Enforces setup, latch-pulse and hold timing so that no latch closes on an undriven bus.
- Sits between the control unit (issues start/select) and the bank of transparent 32-bit registers (accumulator, CI, PI, staticisor, etc.).

---
 rtl/register_transfer_sequencer_pkg.sv | 41 ++++
 rtl/register_transfer_sequencer_if.sv | 40 ++++
 rtl/register_transfer_sequencer_phase_timer.sv | 27 ++
 rtl/register_transfer_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/register_transfer_sequencer_pkg.sv
// Shared types and timing defaults for the register transfer sequencer.
// Optional transfer counter is enabled with XFER_COUNT_EN.
package xfer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRIVE = 3'd1,
    S_LATCH = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } xfer_state_e;

  localparam int DEF_SETUP = 2;
  localparam int DEF_LATCH = 2;
  localparam int DEF_HOLD  = 1;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Timer holds count-1, so max-1 must fit.
  function automatic int timer_w(
    input int s,
    input int l,
    input int h
  );
    int m;
    m = max3(s, l, h);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int TIMER_W =
    timer_w(DEF_SETUP, DEF_LATCH, DEF_HOLD);

endpackage

// File: rtl/register_transfer_sequencer_if.sv
// Control-unit / register-bank handshake bundle of the sequencer.
// Carries xfer_count when XFER_COUNT_EN is defined.
interface register_transfer_sequencer_if #(
  parameter int NUM_SRC = 4,
  parameter int NUM_DST = 4
);
  localparam int SW =
    (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int DW =
    (NUM_DST > 1) ? $clog2(NUM_DST) : 1;

  logic          start;
  logic [SW-1:0] src_sel;
  logic [DW-1:0] dst_sel;
  logic          busy;
  logic          done;
  logic          error;
  logic [NUM_SRC-1:0] oe_n;
  logic [NUM_DST-1:0] le;
`ifdef XFER_COUNT_EN
  logic [15:0]   xfer_count;
`endif

  modport master (
    output start, src_sel, dst_sel,
    input  busy, done, error, oe_n, le
`ifdef XFER_COUNT_EN
    , input xfer_count
`endif
  );

  modport slave (
    input  start, src_sel, dst_sel,
    output busy, done, error, oe_n, le
`ifdef XFER_COUNT_EN
    , output xfer_count
`endif
  );

endinterface

// File: rtl/register_transfer_sequencer_phase_timer.sv
// Loadable down-counter with zero flag, shared by all timed phases.
// No configuration macros.
module phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/register_transfer_sequencer.sv
// Sequences one word transfer between latched registers on a shared bus.
// Define XFER_COUNT_EN to add the xfer_count completed-transfer counter.
module register_transfer_sequencer
  import xfer_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int NUM_DST      = 4,
  parameter int SETUP_CYCLES = DEF_SETUP,
  parameter int LATCH_CYCLES = DEF_LATCH,
  parameter int HOLD_CYCLES  = DEF_HOLD
) (
  input  logic clk,
  input  logic reset,
  register_transfer_sequencer_if.slave io
);

  localparam int SW =
    (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int DW =
    (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
  localparam int TW =
    timer_w(SETUP_CYCLES, LATCH_CYCLES, HOLD_CYCLES);

  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] DRIVE = S_DRIVE;
  localparam logic [2:0] LATCH = S_LATCH;
  localparam logic [2:0] HOLD  = S_HOLD;
  localparam logic [2:0] DONE  = S_DONE;

  logic [2:0]         r_state;
  logic [DW-1:0]      r_dst;
  logic [NUM_SRC-1:0] r_oe_n;
  logic [NUM_DST-1:0] r_le;
  logic               r_busy;
  logic               r_done;
  logic               r_error;

  logic          w_load;
  logic [TW-1:0] w_val;
  logic          w_zero;
  logic          w_src_bad;
  logic          w_dst_bad;
  logic          w_accept;

  // Out-of-range selects exist only for non-power-of-2 counts.
  if (NUM_SRC == (1 << SW)) begin : g_src_p2
    assign w_src_bad = 1'b0;
  end else begin : g_src_np2
    assign w_src_bad =
      ({{(32-SW){1'b0}}, io.src_sel} >= NUM_SRC);
  end

  if (NUM_DST == (1 << DW)) begin : g_dst_p2
    assign w_dst_bad = 1'b0;
  end else begin : g_dst_np2
    assign w_dst_bad =
      ({{(32-DW){1'b0}}, io.dst_sel} >= NUM_DST);
  end

  assign w_accept = (r_state == IDLE) && io.start
                    && !w_src_bad && !w_dst_bad;

  always_comb begin
    w_load = 1'b0;
    w_val  = '0;
    unique case (1'b1)
      w_accept: begin
        w_load = 1'b1;
        w_val  = TW'(SETUP_CYCLES - 1);
      end
      (r_state == DRIVE) && w_zero: begin
        w_load = 1'b1;
        w_val  = TW'(LATCH_CYCLES - 1);
      end
      (r_state == LATCH) && w_zero: begin
        w_load = 1'b1;
        w_val  = TW'(HOLD_CYCLES - 1);
      end
      default: ;
    endcase
  end

  phase_timer #(
    .W (TW)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_val  (w_val),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_dst   <= '0;
      r_oe_n  <= '1;
      r_le    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (w_accept) begin
            r_state <= DRIVE;
            r_dst   <= io.dst_sel;
            r_oe_n  <= ~(NUM_SRC'(1) << io.src_sel);
            r_busy  <= 1'b1;
          end else if (io.start) begin
            r_error <= 1'b1;
          end
        end
        DRIVE: begin
          if (w_zero) begin
            r_state <= LATCH;
            r_le    <= NUM_DST'(1) << r_dst;
          end
        end
        LATCH: begin
          if (w_zero) begin
            r_state <= HOLD;
            r_le    <= '0;
          end
        end
        HOLD: begin
          if (w_zero) begin
            r_state <= DONE;
            r_oe_n  <= '1;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_oe_n  <= '1;
          r_le    <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io.oe_n  = r_oe_n;
  assign io.le    = r_le;
  assign io.busy  = r_busy;
  assign io.done  = r_done;
  assign io.error = r_error;

`ifdef XFER_COUNT_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (r_state == DONE) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign io.xfer_count = r_xfer_count;
`endif

endmodule
